// File: rtl/gerenciador_atributos.sv
// gerenciador_atributos
// Pet-attribute engine for the Tamagotchi core. Holds N_ATTR saturating
// attributes and updates all of them together once per prescaled tick,
// following the raise/hold masks from the behaviour FSM. It raises per-attribute
// low alerts with hysteresis, latches death (which freezes everything until a
// revive) and counts the pet's age in ticks.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   pausa      freezes the prescaler while high
//   sobe       per-attribute raise request, sampled at the update edge
//   segura     per-attribute hold request, sampled at the update edge
//   reviver    restart request, honoured only while dead
//   atributos  packed current values (attr i at [i*WIDTH +: WIDTH])
//   alerta     per-attribute low flag
//   morreu     sticky death flag
//   tick       one-cycle pulse in the cycle the new values appear
//   idade      ticks survived, saturating at 16'hFFFF
module gerenciador_atributos #(
  parameter int                      N_ATTR        = 3,
  parameter int                      WIDTH         = 8,
  parameter int                      MAX_VAL       = 100,
  parameter logic [N_ATTR*WIDTH-1:0] INIT          = {8'd50, 8'd70, 8'd80},
  parameter int                      VEL_SUBIDA    = 7,
  parameter int                      VEL_DESCIDA   = 1,
  parameter int                      TICK_DIV      = 50_000_000,
  parameter int                      LIMIAR_MORTE  = 10,
  parameter int                      LIMIAR_ALERTA = 30,
  parameter int                      HIST          = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pausa,
  input  logic [N_ATTR-1:0]         sobe,
  input  logic [N_ATTR-1:0]         segura,
  input  logic                      reviver,
  output logic [N_ATTR*WIDTH-1:0]   atributos,
  output logic [N_ATTR-1:0]         alerta,
  output logic                      morreu,
  output logic                      tick,
  output logic [15:0]               idade
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int EW    = WIDTH + 1;
  localparam int CW    = WIDTH + 2;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [EW-1:0]    MAX_EXT    = EW'(MAX_VAL);
  localparam logic [EW-1:0]    UP_STEP    = EW'(VEL_SUBIDA);
  localparam logic [EW-1:0]    DOWN_STEP  = EW'(VEL_DESCIDA);
  localparam logic [EW-1:0]    DEATH_LIM  = EW'(LIMIAR_MORTE);
  localparam logic [EW-1:0]    ALERT_SET  = EW'(LIMIAR_ALERTA);
  localparam logic [CW-1:0]    ALERT_CLR  = CW'(LIMIAR_ALERTA + HIST);

  logic [CNT_W-1:0]         cnt;
  logic                     active;
  logic                     updateEdge;
  logic [N_ATTR*WIDTH-1:0]  nextAttr;
  logic [N_ATTR-1:0]        nextAlerta;
  logic                     deathHit;
  logic                     reload;

  // One step of a single attribute. The extra top bit keeps the raise sum from
  // wrapping before it is clamped to MAX_VAL.
  function automatic logic [WIDTH-1:0] nextVal(input logic [WIDTH-1:0] v,
                                               input logic up,
                                               input logic hold);
    logic [EW-1:0] ext;
    logic [EW-1:0] sum;
    ext = {1'b0, v};
    sum = ext + UP_STEP;
    if (up)
      nextVal = (sum > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : sum[WIDTH-1:0];
    else if (hold)
      nextVal = v;
    else if (ext > DOWN_STEP)
      nextVal = WIDTH'(ext - DOWN_STEP);
    else
      nextVal = '0;
  endfunction

  // The prescaler, attributes and age only move while unpaused and alive.
  assign active     = !pausa && !morreu;
  assign updateEdge = active && (cnt == CNT_LAST);
  assign reload     = rst || (reviver && morreu);

  // Candidate next state for every attribute; death and alerts look at the
  // post-update values, not the current ones.
  always_comb begin
    nextAttr   = atributos;
    nextAlerta = alerta;
    deathHit   = 1'b0;
    for (int i = 0; i < N_ATTR; i++) begin
      nextAttr[i*WIDTH +: WIDTH] = nextVal(atributos[i*WIDTH +: WIDTH], sobe[i], segura[i]);
      if ({1'b0, nextAttr[i*WIDTH +: WIDTH]} <= DEATH_LIM)
        deathHit = 1'b1;
      if ({1'b0, nextAttr[i*WIDTH +: WIDTH]} <= ALERT_SET)
        nextAlerta[i] = 1'b1;
      else if ({2'b00, nextAttr[i*WIDTH +: WIDTH]} > ALERT_CLR)
        nextAlerta[i] = 1'b0;
    end
  end

  // Reset and revive share the same reload; otherwise the prescaler advances
  // while active and everything else commits only on the update edge.
  always_ff @(posedge clk) begin
    if (reload) begin
      cnt       <= '0;
      atributos <= INIT;
      alerta    <= '0;
      morreu    <= 1'b0;
      tick      <= 1'b0;
      idade     <= '0;
    end else begin
      tick <= updateEdge;
      if (active)
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      if (updateEdge) begin
        atributos <= nextAttr;
        alerta    <= nextAlerta;
        morreu    <= deathHit;
        if (idade != 16'hFFFF)
          idade <= idade + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gerenciador_atributos.sv
// tb_gerenciador_atributos
// Directed bench for gerenciador_atributos with a fast prescaler (TICK_DIV=4).
// Instance A uses the default start values; instance B starts attr0 at 12 so
// that death and revive can be reached in a few ticks.
module tb_gerenciador_atributos;

  localparam int TD = 4;

  logic        clk = 1'b0;

  logic        rstA = 1'b1, pausaA = 1'b0, reviverA = 1'b0;
  logic [2:0]  sobeA = '0, seguraA = '0;
  logic [23:0] atributosA;
  logic [2:0]  alertaA;
  logic        morreuA, tickA;
  logic [15:0] idadeA;

  logic        rstB = 1'b1, pausaB = 1'b0, reviverB = 1'b0;
  logic [2:0]  sobeB = '0, seguraB = '0;
  logic [23:0] atributosB;
  logic [2:0]  alertaB;
  logic        morreuB, tickB;
  logic [15:0] idadeB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gerenciador_atributos #(.TICK_DIV(TD)) dutA (
    .clk(clk), .rst(rstA), .pausa(pausaA), .sobe(sobeA), .segura(seguraA),
    .reviver(reviverA), .atributos(atributosA), .alerta(alertaA),
    .morreu(morreuA), .tick(tickA), .idade(idadeA)
  );

  gerenciador_atributos #(.TICK_DIV(TD), .INIT({8'd80, 8'd80, 8'd12})) dutB (
    .clk(clk), .rst(rstB), .pausa(pausaB), .sobe(sobeB), .segura(seguraB),
    .reviver(reviverB), .atributos(atributosB), .alerta(alertaB),
    .morreu(morreuB), .tick(tickB), .idade(idadeB)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic stepEdge;
    @(posedge clk);
    #1;
  endtask

  // Advance until the chosen instance pulses tick, with a cycle budget.
  task automatic runToTick(input bit useB, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * TD; i++) begin
      stepEdge();
      if ((useB ? tickB : tickA) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s: tick not seen within %0d cycles (required within budget)", name, 3 * TD);
    end
  endtask

  task automatic resetA;
    rstA = 1'b1;
    stepEdge();
    stepEdge();
    rstA = 1'b0;
  endtask

  task automatic test_reset;
    rstA = 1'b1; sobeA = '0; seguraA = '0; pausaA = 1'b0; reviverA = 1'b0;
    stepEdge();
    stepEdge();
    checks++;
    if (atributosA !== {8'd50, 8'd70, 8'd80}) begin
      errors++; $display("[TB] FAIL reset_attr: got %h required %h", atributosA, {8'd50, 8'd70, 8'd80});
    end
    checks++;
    if ({morreuA, alertaA, tickA} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got morreu=%b alerta=%b tick=%b required 0", morreuA, alertaA, tickA);
    end
    checks++;
    if (idadeA !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_idade: got %0d required 0", idadeA);
    end
    rstA = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      stepEdge();
      checks++;
      if (tickA !== 1'b0 || atributosA !== {8'd50, 8'd70, 8'd80}) begin
        errors++; $display("[TB] FAIL early_edge%0d: got tick=%b attr=%h required tick=0 attr=324650", e, tickA, atributosA);
      end
    end
  endtask

  task automatic test_first_tick;
    stepEdge();
    checks++;
    if (tickA !== 1'b1 || atributosA !== {8'd49, 8'd69, 8'd79} || idadeA !== 16'd1) begin
      errors++; $display("[TB] FAIL first_tick: got tick=%b attr=%h idade=%0d required 1 31454f 1", tickA, atributosA, idadeA);
    end
    stepEdge();
    checks++;
    if (tickA !== 1'b0) begin
      errors++; $display("[TB] FAIL tick_width: got %b required 0", tickA);
    end
  endtask

  task automatic test_saturation;
    logic [7:0] exp0 [4];
    exp0[0] = 8'd87; exp0[1] = 8'd94; exp0[2] = 8'd100; exp0[3] = 8'd100;
    resetA();
    sobeA = 3'b001; seguraA = 3'b110;
    for (int k = 0; k < 4; k++) begin
      runToTick(1'b0, "sat_tick");
      checks++;
      if (atributosA[7:0] !== exp0[k]) begin
        errors++; $display("[TB] FAIL sat_attr0_%0d: got %0d required %0d", k, atributosA[7:0], exp0[k]);
      end
    end
    checks++;
    if (atributosA[23:8] !== {8'd50, 8'd70} || idadeA !== 16'd4) begin
      errors++; $display("[TB] FAIL sat_held: got attr2/1=%h idade=%0d required 3246 4", atributosA[23:8], idadeA);
    end
    // attr1 has both raise and hold set; raise must win
    sobeA = 3'b010; seguraA = 3'b011;
    runToTick(1'b0, "prio_tick");
    checks++;
    if (atributosA !== {8'd49, 8'd77, 8'd100}) begin
      errors++; $display("[TB] FAIL raise_priority: got %h required %h", atributosA, {8'd49, 8'd77, 8'd100});
    end
  endtask

  task automatic test_pause;
    logic [23:0] held;
    sobeA = '0; seguraA = '0;
    stepEdge();
    stepEdge();
    held = atributosA;
    pausaA = 1'b1;
    for (int k = 0; k < 10; k++) begin
      stepEdge();
      checks++;
      if (tickA !== 1'b0 || atributosA !== held) begin
        errors++; $display("[TB] FAIL pause_%0d: got tick=%b attr=%h required 0 %h", k, tickA, atributosA, held);
      end
    end
    pausaA = 1'b0;
    stepEdge();
    checks++;
    if (tickA !== 1'b0) begin
      errors++; $display("[TB] FAIL pause_resume1: got tick=%b required 0", tickA);
    end
    stepEdge();
    checks++;
    if (tickA !== 1'b1 || atributosA !== {8'd48, 8'd76, 8'd99} || idadeA !== 16'd6) begin
      errors++; $display("[TB] FAIL pause_resume2: got tick=%b attr=%h idade=%0d required 1 304c63 6", tickA, atributosA, idadeA);
    end
  endtask

  task automatic test_alert_hysteresis;
    resetA();
    sobeA = '0; seguraA = 3'b011;
    for (int k = 0; k < 19; k++) runToTick(1'b0, "alert_decay");
    checks++;
    if (atributosA[23:16] !== 8'd31 || alertaA !== 3'b000) begin
      errors++; $display("[TB] FAIL alert_at31: got v=%0d alerta=%b required 31 000", atributosA[23:16], alertaA);
    end
    runToTick(1'b0, "alert_decay");
    checks++;
    if (atributosA[23:16] !== 8'd30 || alertaA !== 3'b100) begin
      errors++; $display("[TB] FAIL alert_at30: got v=%0d alerta=%b required 30 100", atributosA[23:16], alertaA);
    end
    for (int k = 0; k < 4; k++) runToTick(1'b0, "alert_decay");
    sobeA = 3'b100;
    runToTick(1'b0, "alert_raise");
    checks++;
    if (atributosA[23:16] !== 8'd33 || alertaA !== 3'b100) begin
      errors++; $display("[TB] FAIL alert_at33: got v=%0d alerta=%b required 33 100", atributosA[23:16], alertaA);
    end
    runToTick(1'b0, "alert_raise");
    checks++;
    if (atributosA !== {8'd40, 8'd70, 8'd80} || alertaA !== 3'b000 || idadeA !== 16'd26) begin
      errors++; $display("[TB] FAIL alert_at40: got attr=%h alerta=%b idade=%0d required 284650 000 26", atributosA, alertaA, idadeA);
    end
  endtask

  task automatic test_revive_alive;
    sobeA = '0; seguraA = 3'b111; reviverA = 1'b1;
    stepEdge();
    stepEdge();
    checks++;
    if (atributosA !== {8'd40, 8'd70, 8'd80} || idadeA !== 16'd26) begin
      errors++; $display("[TB] FAIL revive_alive: got attr=%h idade=%0d required 284650 26", atributosA, idadeA);
    end
    runToTick(1'b0, "revive_alive_tick");
    checks++;
    if (idadeA !== 16'd27) begin
      errors++; $display("[TB] FAIL revive_alive_idade: got %0d required 27", idadeA);
    end
    reviverA = 1'b0;
  endtask

  task automatic test_death;
    rstB = 1'b1;
    stepEdge();
    rstB = 1'b0;
    runToTick(1'b1, "death_tick1");
    checks++;
    if (atributosB !== {8'd79, 8'd79, 8'd11} || morreuB !== 1'b0) begin
      errors++; $display("[TB] FAIL death_at11: got attr=%h morreu=%b required 4f4f0b 0", atributosB, morreuB);
    end
    runToTick(1'b1, "death_tick2");
    checks++;
    if (atributosB !== {8'd78, 8'd78, 8'd10} || morreuB !== 1'b1 || idadeB !== 16'd2) begin
      errors++; $display("[TB] FAIL death_at10: got attr=%h morreu=%b idade=%0d required 4e4e0a 1 2", atributosB, morreuB, idadeB);
    end
    for (int k = 0; k < 10; k++) begin
      stepEdge();
      checks++;
      if (tickB !== 1'b0 || atributosB !== {8'd78, 8'd78, 8'd10} || idadeB !== 16'd2 || morreuB !== 1'b1) begin
        errors++; $display("[TB] FAIL dead_frozen_%0d: got tick=%b attr=%h idade=%0d morreu=%b", k, tickB, atributosB, idadeB, morreuB);
      end
    end
  endtask

  task automatic test_revive;
    reviverB = 1'b1;
    stepEdge();
    reviverB = 1'b0;
    checks++;
    if (atributosB !== {8'd80, 8'd80, 8'd12} || morreuB !== 1'b0 || idadeB !== 16'd0 || tickB !== 1'b0) begin
      errors++; $display("[TB] FAIL revive_state: got attr=%h morreu=%b idade=%0d tick=%b required 50500c 0 0 0", atributosB, morreuB, idadeB, tickB);
    end
    for (int e = 1; e <= 3; e++) begin
      stepEdge();
      checks++;
      if (tickB !== 1'b0) begin
        errors++; $display("[TB] FAIL revive_early%0d: got tick=%b required 0", e, tickB);
      end
    end
    stepEdge();
    checks++;
    if (tickB !== 1'b1 || atributosB !== {8'd79, 8'd79, 8'd11}) begin
      errors++; $display("[TB] FAIL revive_first_tick: got tick=%b attr=%h required 1 4f4f0b", tickB, atributosB);
    end
    runToTick(1'b1, "redeath_tick");
    checks++;
    if (morreuB !== 1'b1) begin
      errors++; $display("[TB] FAIL redeath: got morreu=%b required 1", morreuB);
    end
    rstB = 1'b1; reviverB = 1'b1;
    stepEdge();
    rstB = 1'b0; reviverB = 1'b0;
    checks++;
    if (atributosB !== {8'd80, 8'd80, 8'd12} || morreuB !== 1'b0 || idadeB !== 16'd0 || alertaB !== 3'b000) begin
      errors++; $display("[TB] FAIL rst_and_revive: got attr=%h morreu=%b idade=%0d alerta=%b", atributosB, morreuB, idadeB, alertaB);
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_saturation();
    test_pause();
    test_alert_hysteresis();
    test_revive_alive();
    test_death();
    test_revive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gerenciador_atributos.md
# gerenciador_atributos

Parametrised pet-attribute engine for the Tamagotchi core: holds N_ATTR saturating attributes (hunger, happiness, sleep, ...), updates them once per prescaled tick according to per-attribute raise/hold masks from the behaviour FSM, and raises per-attribute low alerts with hysteresis. It latches death, freezes, and supports a revive command. It also counts the pet's age in ticks. It sits between the behaviour/state FSM and the display/sound blocks.

## Interface
- N_ATTR, 3: number of attributes (channels), 1..8.
- WIDTH, 8: bits per attribute.
- MAX_VAL, 100: saturation ceiling. Must satisfy MAX_VAL < 2^WIDTH.
- INIT, {8'd50, 8'd70, 8'd80}: packed N_ATTR*WIDTH start values. Attribute i is INIT[i*WIDTH +: WIDTH]. Defaults: attr0 = 80, attr1 = 70, attr2 = 50.
- VEL_SUBIDA, 7: raise step per tick.
- VEL_DESCIDA, 1: decay step per tick.
- TICK_DIV, 50_000_000: clk cycles per tick. Must be ≥ 2.
- LIMIAR_MORTE, 10: death threshold (≤).
- LIMIAR_ALERTA, 30: alert set threshold (≤).
- HIST, 5: alert clear margin.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pausa  in  1  freezes the prescaler; nothing changes while high.
- sobe  in  N_ATTR  bit i = raise attribute i on the next tick.
- segura  in  N_ATTR  bit i = hold attribute i on the next tick.
- reviver  in  1  restart request; honoured only while dead.
- atributos  out  N_ATTR*WIDTH  packed current values, same layout as INIT.
- alerta  out  N_ATTR  bit i = attribute i is low.
- morreu  out  1  death latch.
- tick  out  1  one-cycle pulse, high in the cycle after an update edge.
- idade  out  16  ticks survived; saturates at 16'hFFFF.

## Operation
- Prescaler
  - The prescaler counter counts 0..TICK_DIV-1, then wraps.
  - It increments only when pausa=0 and morreu=0; otherwise it holds its value.
- Update edge
  - An update edge is an edge where the counter = TICK_DIV-1, pausa=0 and morreu=0.
  - On it, every attribute updates together and idade increments (saturating).
- Per-attribute rule on an update edge, with priority sobe > segura > decay:
  - Raise: v > MAX_VAL-VEL_SUBIDA ? MAX_VAL : v+VEL_SUBIDA.
  - Hold: v unchanged.
  - Decay: v > VEL_DESCIDA ? v-VEL_DESCIDA : 0.
  - Compute in WIDTH+1 bits; no wrap-around is permitted.
- Death
  - On an update edge, morreu is set if any **new** value ≤ LIMIAR_MORTE.
  - The check uses post-update values, not the previous ones.
  - Once set, morreu is sticky. Attributes, alerta, idade and the prescaler freeze, and tick stays 0.
- Alerts, evaluated on new values at each update edge:
  - bit i sets when the value ≤ LIMIAR_ALERTA.
  - bit i clears when the value > LIMIAR_ALERTA+HIST.
  - Otherwise bit i holds.
- Revive
  - reviver=1 while morreu=1 reloads the reset state on that edge.
  - reviver is ignored while morreu=0.
- Reset state: atributos=INIT, morreu=0, alerta=0, idade=0, tick=0, prescaler=0.
- Precedence: rst > reviver > update edge.

## Timing
- Clock edges count from the first edge with rst=0.
- The first update edge is the TICK_DIV-th such edge (counter 0→TICK_DIV-1 takes TICK_DIV-1 edges, then the update).
- Later updates come every TICK_DIV unpaused cycles.
- New atributos, alerta, morreu and idade become visible in the same cycle that tick is high.
- Pausa semantics: prescaler progress is preserved. After pausa falls, the remaining count continues and the count does not restart.
- Revive latency: the values are INIT in the cycle after the reviver edge, and the next update follows TICK_DIV edges later.
- Inputs sobe and segura are sampled only at the update edge; values between ticks are don't-care.
- Combinational input→output paths: none.

## Test plan
- **Reset and first tick** (TICK_DIV=4, defaults, sobe=segura=0):
  - After rst: atributos=80/70/50, morreu=0, alerta=0, idade=0.
  - On the 4th edge after release: 79/69/49, tick=1 for one cycle, idade=1.
- **Saturation** (sobe=3'b001, segura=3'b110, attr0 from 80):
  - attr0 goes 87, 94, 100, 100 over successive ticks.
  - attr1 and attr2 stay unchanged.
  - sobe and segura both set on the same bit: raise wins.
- **Death** (INIT attr0=12, others 80, sobe=0):
  - attr0 goes 11, then 10; morreu=1 in the same cycle attr0 shows 10.
  - Further cycles: values frozen, tick=0, idade frozen.
- **Revive**:
  - reviver=1 while dead: next cycle atributos=INIT, morreu=0, idade=0; the first tick comes 4 edges later.
  - reviver=1 while alive: no effect.
  - rst and reviver asserted together: reset state.
- **Pause**:
  - Assert pausa 2 edges after a tick and hold it 10 cycles: no tick, values steady.
  - After release, the next tick arrives 2 edges later.
- **Alert hysteresis** (LIMIAR_ALERTA=30, HIST=5, attr decaying from 31):
  - At 30: alerta=1.
  - Decay to 26, then raise: 33 keeps alerta=1, 40 clears it.
